// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with FWFT receive FIFO and sticky error flags
// Ports: clk/rst_n (async active-low), rx serial in, rd_en pop, clear_errors pulse,
//        rd_data head byte, empty/full/count FIFO status, busy frame in progress,
//        overrun/frame_error sticky flags.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ  = 25000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rx,
  input  logic                           rd_en,
  input  logic                           clear_errors,
  output logic [7:0]                     rd_data,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(BUFFER_SIZE):0]   count,
  output logic                           busy,
  output logic                           overrun,
  output logic                           frame_error
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic sync_q, sync_d, rxs_q, rxs_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic push_q, push_d;
  logic [7:0] mem_q [BUFFER_SIZE];
  logic [7:0] mem_d [BUFFER_SIZE];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overrun_q, overrun_d, ferr_q, ferr_d;
  logic tick, stop_tick, do_pop, do_push;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rxs_q ? IDLE : START;
      START:   state_d = !tick ? START : (rxs_q ? IDLE : DATA);
      DATA:    state_d = (tick && bit_q == 3'd7) ? STOP : DATA;
      STOP:    state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb busy = state_q != IDLE;
  always_comb begin
    sync_d = rx;
    rxs_d = sync_q;
    tick = (state_q == START) ? (tmr_q == HALF_END) : (tmr_q == BIT_END);
    stop_tick = state_q == STOP && tick;
    tmr_d = (state_q == IDLE || tick) ? '0 : tmr_q + 1'b1;
    bit_d = (state_q != DATA) ? 3'd0 : bit_q + 3'(tick);
    shift_d = (state_q == DATA && tick) ? {rxs_q, shift_q[7:1]} : shift_q;
    // the byte is pushed one cycle after the good stop-bit sample
    push_d = stop_tick && rxs_q;
    do_pop = rd_en && !empty;
    // a simultaneous pop frees the slot a full FIFO needs
    do_push = push_q && (!full || do_pop);
    overrun_d = (push_q && !do_push) || (overrun_q && !clear_errors);
    ferr_d = (stop_tick && !rxs_q) || (ferr_q && !clear_errors);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = shift_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      rxs_q <= 1'b1;
      tmr_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      push_q <= 1'b0;
      mem_q <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      overrun_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rxs_q <= rxs_d;
      tmr_q <= tmr_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      push_q <= push_d;
      mem_q <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      overrun_q <= overrun_d;
      ferr_q <= ferr_d;
    end
  end
  assign empty = count_q == '0;
  assign full = count_q == CW'(BUFFER_SIZE);
  assign count = count_q;
  assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overrun = overrun_q;
  assign frame_error = ferr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rd_en = 1'b0, clear_errors = 1'b0;
  logic [7:0] rd_data;
  logic empty, full, busy, overrun, frame_error;
  logic [2:0] count;
  int checks = 0, errors = 0;
  int lat;
  logic seen, done;
  always #5 clk = ~clk;
  uart_rx_fifo #(.CLOCK_FREQ(160), .BAUD_RATE(10), .BUFFER_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .clear_errors(clear_errors),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .busy(busy),
    .overrun(overrun), .frame_error(frame_error)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop_bit);
    @(posedge clk) #1 rx = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (16) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (16) @(posedge clk);
    #1 rx = 1'b1;
  endtask
  task automatic pop();
    @(negedge clk) rd_en = 1'b1;
    @(posedge clk) #1 rd_en = 1'b0;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clr();
    @(negedge clk) clear_errors = 1'b1;
    @(negedge clk) clear_errors = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    idle(3);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overrun, frame_error}, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    idle(4);
    lat = -1;
    fork
      send(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 300; i++) begin
          @(posedge clk);
          #1;
          if (!empty) begin
            lat = i - 1;
            break;
          end
        end
      end
    join
    chk("a5_latency", (lat >= 154 && lat <= 156), 1);
    idle(1);
    chk("a5_data", rd_data, 8'hA5);
    chk("a5_count", count, 1);
    chk("a5_flags", {overrun, frame_error}, 0);
    pop();
    chk("a5_pop_empty", empty, 1);
    chk("a5_pop_count", count, 0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    idle(2);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    send(8'h05, 1'b1);
    idle(2);
    chk("ovr_flag", overrun, 1);
    chk("ovr_count", count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_read", rd_data, 32'(i));
      pop();
    end
    chk("ovr_drained", empty, 1);
    clr();
    chk("ovr_cleared", overrun, 0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    idle(2);
    chk("sim_full", full, 1);
    seen = 1'b0;
    done = 1'b0;
    fork
      send(8'h05, 1'b1);
      begin
        for (int i = 0; i < 400 && !done; i++) begin
          @(negedge clk);
          if (busy) seen = 1'b1;
          else if (seen) done = 1'b1;
        end
        if (done) begin
          rd_en = 1'b1;
          @(posedge clk) #1 rd_en = 1'b0;
        end
      end
    join
    chk("sim_busy_fall_seen", done, 1);
    idle(2);
    chk("sim_overrun", overrun, 0);
    chk("sim_count", count, 4);
    for (int i = 2; i <= 5; i++) begin
      chk("sim_read", rd_data, 32'(i));
      pop();
    end
    chk("sim_drained", empty, 1);
    seen = 1'b0;
    fork
      begin
        @(posedge clk) #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (busy) seen = 1'b1;
        end
      end
    join
    chk("glitch_busy_pulse", seen, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_empty", empty, 1);
    chk("glitch_flags", {overrun, frame_error}, 0);
    send(8'h3C, 1'b0);
    idle(20);
    chk("ferr_flag", frame_error, 1);
    chk("ferr_empty", empty, 1);
    send(8'h7E, 1'b1);
    idle(2);
    chk("after_ferr_data", rd_data, 8'h7E);
    chk("after_ferr_count", count, 1);
    chk("ferr_sticky", frame_error, 1);
    fork
      send(8'h22, 1'b1);
      begin
        repeat (16 * 5 + 8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_count", count, 0);
        chk("midrst_data", rd_data, 8'h00);
        chk("midrst_flags", {overrun, frame_error, full}, 0);
      end
    join
    @(posedge clk) #1 rst_n = 1'b1;
    idle(4);
    send(8'h5A, 1'b1);
    idle(2);
    chk("post_rst_data", rd_data, 8'h5A);
    chk("post_rst_count", count, 1);
    chk("post_rst_flags", {overrun, frame_error}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with an integrated receive FIFO, for 8N1 serial data arriving on the SoC `rx` pin. It is the receive-side counterpart of the SoC UART transmitter and uses the same `CLOCK_FREQ`/`BAUD_RATE` parameterisation. It deserialises bytes, buffers them in `BUFFER_SIZE` entries and presents them to the bus-side peripheral logic through a first-word-fall-through read port with sticky error flags.

## Interface
- `CLOCK_FREQ`, 25000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: serial bit rate.
- `BUFFER_SIZE`, 16: FIFO depth. Must be a power of two and at least 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input. Asynchronous to `clk`; idles high.
- `rd_en`  in  1  pop the head entry. Ignored when `empty`=1.
- `clear_errors`  in  1  one-cycle pulse that clears `overrun` and `frame_error`.
- `rd_data`  out  8  FIFO head byte. Valid while `empty`=0.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `BUFFER_SIZE` bytes.
- `count`  out  $clog2(BUFFER_SIZE)+1  number of stored bytes.
- `busy`  out  1  a frame is currently being received (state is not IDLE).
- `overrun`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `frame_error`  out  1  sticky: a stop bit was sampled low.

## Operation
- `CLKS_PER_BIT` = CLOCK_FREQ/BAUD_RATE, integer division; 217 at the defaults. `HALF_BIT` = CLKS_PER_BIT/2.
- `rx` passes through a 2-flop synchroniser, reset to 1. All state-machine decisions use the synchronised value `rxs`.
- States and transitions:
  - IDLE: when `rxs`=0, clear the bit timer and go to START.
  - START: after `HALF_BIT` cycles, resample. If `rxs`=0, go to DATA. If `rxs`=1, treat it as a glitch and return to IDLE; no flag is set.
  - DATA: every `CLKS_PER_BIT` cycles, sample one bit into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample the stop bit, then return to IDLE.
    - Stop bit = 1 and FIFO not full: push the byte.
    - Stop bit = 1, FIFO full, `rd_en`=0: drop the byte and set `overrun`.
    - Stop bit = 0: discard the byte and set `frame_error`.
- FIFO storage:
  - Circular buffer with read and write pointers of $clog2(BUFFER_SIZE) bits; pointers wrap naturally.
  - `count` is a separate counter: it increments on push-only and decrements on pop-only.
- Simultaneous push and pop:
  - Both happen and `count` is unchanged.
  - If the FIFO is full, the pop frees a slot, so the push is accepted with no overrun.
  - If the FIFO is empty, only the push takes effect because `rd_en` is ignored.
- Sticky flags: a set event in the same cycle as `clear_errors` wins, and the flag stays 1.
- Reset mid-frame: the partial byte is abandoned, the FIFO is emptied and all flags are cleared. Receiving restarts at the next low `rxs` seen in IDLE.

## Timing
- Reset values:
  - `rd_data`=0x00, `empty`=1, `full`=0, `count`=0.
  - `busy`=0, `overrun`=0, `frame_error`=0.
  - State = IDLE, synchroniser = 1.
- All outputs are registered or decoded directly from registers; there is no combinational path from `rx`.
- Latency:
  - Push is registered on the cycle after the stop-bit sample.
  - `empty` falls 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles after the `rx` falling edge, ±1 cycle of synchroniser phase.
- Sample points sit at mid-bit, with error ≤ 1 cycle plus synchroniser delay.
- Pop:
  - `rd_data`, `count`, `empty` and `full` update on the clock edge that samples `rd_en`=1.
  - The next byte is visible in the following cycle.
- `busy` rises on the cycle the state leaves IDLE and falls on the cycle it returns to IDLE.

## Test plan
Bench parameters: CLOCK_FREQ=160, BAUD_RATE=10, giving CLKS_PER_BIT=16. BUFFER_SIZE=4.
- Single frame 0xA5, `rx` driven with 16 cycles per bit -> `empty` falls within the latency window, `rd_data`=0xA5, `count`=1, no flags set; after one `rd_en` -> `empty`=1, `count`=0.
- Five back-to-back frames 0x01..0x05 with no reads -> `full`=1 and `count`=4 after the 4th frame; 0x05 is dropped and `overrun`=1; reads return 0x01..0x04 in order; `clear_errors` -> `overrun`=0.
- FIFO full, with `rd_en` asserted in the exact cycle the 5th byte is pushed -> `overrun`=0, `count` stays 4, and the FIFO then drains 0x02, 0x03, 0x04, 0x05.
- Start glitch: `rx` low for 5 cycles -> `busy` pulses and returns to 0, `empty` stays 1, no flags set.
- Frame 0x3C with the stop bit driven 0 -> `frame_error`=1, `empty`=1; a following good frame 0x7E is received correctly.
- `rst_n` asserted low during bit 4 of a frame -> all outputs return to their reset values immediately; the next complete frame 0x5A is received correctly.
